// File: rtl/apb3_cmd_master_if.sv
// apb3_cmd_master_if: command/response handshake plus APB3 bus of the command master.
// The master modport is the initiator view; slave is the command source / APB peripheral side.
interface apb3_cmd_master_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
) ();
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [AWIDTH-1:0] cmd_addr;
  logic [DWIDTH-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [AWIDTH-1:0] PADDR;
  logic [DWIDTH-1:0] PWDATA;
  logic [DWIDTH-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb3_cmd_master.sv
// apb3_cmd_master: turns single-beat valid/ready commands into APB3 SETUP/ACCESS transfers.
// Define APB_MASTER_TIMEOUT_EN to abort transfers whose PREADY stays low for TIMEOUT cycles.
module apb3_cmd_master #(
  parameter int AWIDTH  = 10,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 256
) (
  input logic               PCLK,
  input logic               PRESETN,
  apb3_cmd_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [AWIDTH-1:0] paddr_q, paddr_d;
  logic [DWIDTH-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              abort;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] wait_cnt_q, wait_cnt_d;

  // SETUP always precedes ACCESS, so clearing there restarts the count for every transfer.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == SETUP) begin
      wait_cnt_d = '0;
    end else if ((state_q == ACCESS) && !bus.PREADY) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign abort = (state_q == ACCESS) && !bus.PREADY && (wait_cnt_q == TIMEOUT_LAST);
`else
  // TIMEOUT only matters when the abort counter is built.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_LAST;
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = 1'b0;
    psel_d        = 1'b0;
    penable_d     = 1'b0;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (bus.cmd_valid && cmd_ready_q) begin
          pwrite_d    = bus.cmd_write;
          paddr_d     = bus.cmd_addr;
          pwdata_d    = bus.cmd_wdata;
          psel_d      = 1'b1;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (bus.PREADY) begin
          rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d     = bus.PSLVERR;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else if (abort) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = RESP;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      RESP: begin
        cmd_ready_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.PSEL        = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = paddr_q;
  assign bus.PWDATA      = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb3_cmd_master.sv
// tb_apb3_cmd_master: randomized commands against an APB slave model, checked each cycle
// against a transfer-timeline reference model plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_apb3_cmd_master;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct {
    int          n;
    logic        wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int          w;
    logic        e;
  } txn_t;
  typedef struct {
    int   w;
    logic e;
  } plan_t;

  logic PCLK = 1'b0;
  logic PRESETN;
  always #5 PCLK = ~PCLK;

  apb3_cmd_master_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  apb3_cmd_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK   (PCLK),
    .PRESETN(PRESETN),
    .bus    (bus.master)
  );

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int rel = 0;
  int last_acc_n = 0;
  int psel_cnt = 0;
  int pen_cnt = 0;
  int rsp_cnt = 0;
  int rsp_lat = 0;

  txn_t  txn_q[$];
  plan_t mplan_q[$];
  plan_t splan_q[$];
  logic [DW-1:0] mem_m [1024];
  logic [DW-1:0] smem  [1024];

  logic          acc_seen = 1'b0;
  logic          acc_wr;
  logic [AW-1:0] acc_a;
  logic [DW-1:0] acc_d;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int access_len(input int w);
    return (TO_EN && (w >= TO)) ? TO : w + 1;
  endfunction

  // APB slave: wait states and error come from the per-command plan.
  int   s_wait = 0;
  logic s_err = 1'b0;
  plan_t sp;
  always @(posedge PCLK) begin
    #1;
    if (bus.PSEL && !bus.PENABLE) begin
      if (splan_q.size() > 0) begin
        sp = splan_q.pop_front();
        s_wait = sp.w;
        s_err = sp.e;
      end
      bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;
    end else if (bus.PSEL && bus.PENABLE) begin
      if (s_wait > 0) begin
        s_wait--;
        bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;
      end else begin
        bus.PREADY = 1'b1;
        bus.PSLVERR = s_err;
        bus.PRDATA = bus.PWRITE ? $urandom : smem[bus.PADDR];
        if (bus.PWRITE && !s_err) smem[bus.PADDR] = bus.PWDATA;
      end
    end else begin
      bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = $urandom;
    end
  end

  // Acceptance monitor: values sampled at the previous falling edge predict this edge.
  always @(posedge PCLK) begin
    cyc++;
    if (!PRESETN) rel = 0;
    else if (rel < 2) rel++;
    if (PRESETN && acc_seen) begin
      chk("accept_has_plan", mplan_q.size() > 0, 1);
      if (mplan_q.size() > 0) begin
        plan_t p;
        txn_t t;
        p = mplan_q.pop_front();
        t.n = cyc; t.wr = acc_wr; t.a = acc_a; t.d = acc_d; t.w = p.w; t.e = p.e;
        txn_q.push_back(t);
        last_acc_n = cyc;
        psel_cnt = 0;
        pen_cnt = 0;
      end
    end
  end

  // Reference model: each accepted command occupies SETUP, its ACCESS cycles, then RESP.
  logic [AW-1:0] l_a = '0;
  logic          l_wr = 1'b0;
  logic [DW-1:0] l_d = '0;
  logic [DW-1:0] l_rd = '0;
  logic          l_e = 1'b0;
  logic          l_to = 1'b0;
  logic          x_sel, x_en, x_rv, x_rdy;
  txn_t          ct;
  int            off, acl;
  always @(negedge PCLK) begin
    if (!PRESETN) begin
      txn_q.delete();
      l_a = '0; l_wr = 1'b0; l_d = '0; l_rd = '0; l_e = 1'b0; l_to = 1'b0;
      chk("rst_psel", bus.PSEL, 0);
      chk("rst_penable", bus.PENABLE, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_bus", {bus.PWRITE, bus.PADDR, bus.PWDATA}, 0);
      chk("rst_rsp", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 0);
    end else begin
      if (bus.PSEL) psel_cnt++;
      if (bus.PENABLE) pen_cnt++;
      if (bus.rsp_valid) begin
        rsp_cnt++;
        rsp_lat = cyc - last_acc_n;
      end
      x_sel = 1'b0; x_en = 1'b0; x_rv = 1'b0; x_rdy = (rel >= 1);
      if (txn_q.size() > 0) begin
        ct = txn_q[0];
        off = cyc - ct.n;
        acl = access_len(ct.w);
        x_rdy = 1'b0;
        l_a = ct.a; l_wr = ct.wr; l_d = ct.d;
        if (off == 0) begin
          x_sel = 1'b1;
        end else if (off <= acl) begin
          x_sel = 1'b1;
          x_en = 1'b1;
        end else begin
          x_rv = 1'b1;
          l_to = TO_EN && (ct.w >= TO);
          l_e  = l_to ? 1'b1 : ct.e;
          l_rd = (l_to || ct.wr) ? '0 : mem_m[ct.a];
          if (ct.wr && !l_e) mem_m[ct.a] = ct.d;
          void'(txn_q.pop_front());
        end
      end
      chk("psel", bus.PSEL, x_sel);
      chk("penable", bus.PENABLE, x_en);
      chk("rsp_valid", bus.rsp_valid, x_rv);
      chk("cmd_ready", bus.cmd_ready, x_rdy);
      chk("apb_addr_dir_data", {bus.PWRITE, bus.PADDR, bus.PWDATA}, {l_wr, l_a, l_d});
      chk("rsp_fields", {bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, {l_e, l_to, l_rd});
    end
    acc_seen = PRESETN && bus.cmd_valid && bus.cmd_ready;
    acc_wr = bus.cmd_write;
    acc_a = bus.cmd_addr;
    acc_d = bus.cmd_wdata;
  end

  task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input int w, input logic e);
    plan_t p;
    int guard;
    p.w = w; p.e = e;
    mplan_q.push_back(p);
    splan_q.push_back(p);
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = a; bus.cmd_wdata = d;
    guard = 0;
    do begin
      @(negedge PCLK);
      guard++;
    end while (!bus.cmd_ready && guard < 400);
    if (!bus.cmd_ready) begin
      $display("FAIL accept_wait: cmd_ready stayed %0b, required 1 within 400 cycles", bus.cmd_ready);
      $fatal(1);
    end
    @(posedge PCLK);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    do begin
      @(negedge PCLK);
      #1;
      guard++;
    end while ((txn_q.size() != 0 || mplan_q.size() != 0) && guard < 400);
    if (txn_q.size() != 0 || mplan_q.size() != 0) begin
      $display("FAIL drain_wait: %0d transfers pending, required 0 within 400 cycles", txn_q.size());
      $fatal(1);
    end
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    int c0;
    logic wr, e;
    int w;
    PRESETN = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    for (int i = 0; i < 1024; i++) begin
      mem_m[i] = 32'(i) * 32'h0001_0003;
      smem[i]  = 32'(i) * 32'h0001_0003;
    end
    mem_m[10'h020] = 32'h1234_5678;
    smem[10'h020]  = 32'h1234_5678;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_psel_lit", bus.PSEL, 0);
    chk("reset_cmd_ready_lit", bus.cmd_ready, 0);
    @(negedge PCLK);
    #2 PRESETN = 1'b1;
    @(posedge PCLK);
    #1;
    chk("release_cmd_ready_lit", bus.cmd_ready, 1);

    send(1'b1, 10'h010, 32'hDEAD_BEEF, 0, 1'b0);
    wait_idle();
    chk("wr_latency_lit", rsp_lat, 2);
    chk("wr_psel_cycles_lit", psel_cnt, 2);
    chk("wr_slave_mem_lit", smem[10'h010], 32'hDEAD_BEEF);
    chk("wr_err_lit", bus.rsp_err, 0);

    send(1'b0, 10'h020, 32'h0, 3, 1'b0);
    wait_idle();
    chk("rd3_latency_lit", rsp_lat, 5);
    chk("rd3_penable_cycles_lit", pen_cnt, 4);
    chk("rd3_rdata_lit", bus.rsp_rdata, 32'h1234_5678);

    send(1'b0, 10'h030, 32'h0, 1, 1'b1);
    wait_idle();
    chk("err_rd_lit", bus.rsp_err, 1);
    send(1'b1, 10'h031, 32'h0BAD_CAFE, 0, 1'b0);
    wait_idle();
    chk("err_clear_lit", bus.rsp_err, 0);
    chk("wr_rdata_zero_lit", bus.rsp_rdata, 0);

    c0 = rsp_cnt;
    send(1'b1, 10'h0A0, 32'h1111_1111, 0, 1'b0);
    send(1'b0, 10'h0A0, 32'h0, 1, 1'b0);
    send(1'b1, 10'h0A1, 32'h2222_2222, 2, 1'b0);
    wait_idle();
    chk("b2b_rsp_count_lit", rsp_cnt - c0, 3);
    chk("b2b_mem_lit", smem[10'h0A1], 32'h2222_2222);

    c0 = rsp_cnt;
    send(1'b0, 10'h040, 32'h0, 20, 1'b0);
    repeat (5) @(posedge PCLK);
    @(negedge PCLK);
    chk("pre_reset_penable_lit", bus.PENABLE, 1);
    #2 PRESETN = 1'b0;
    #1;
    chk("async_reset_psel_en_lit", {bus.PSEL, bus.PENABLE}, 0);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    #2 PRESETN = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    chk("reset_no_rsp_lit", rsp_cnt - c0, 0);
    chk("reset_ready_again_lit", bus.cmd_ready, 1);
    send(1'b1, 10'h041, 32'hCAFE_F00D, 1, 1'b0);
    wait_idle();
    chk("after_reset_mem_lit", smem[10'h041], 32'hCAFE_F00D);

    send(1'b0, 10'h050, 32'h0, 120, 1'b0);
    wait_idle();
    chk("long_wait_psel_lit", psel_cnt, TO_EN ? 9 : 122);
    chk("long_wait_timeout_lit", bus.rsp_timeout, TO_EN ? 1 : 0);
    send(1'b0, 10'h051, 32'h0, TO - 1, 1'b0);
    wait_idle();
    chk("limit_minus1_timeout_lit", bus.rsp_timeout, 0);
    chk("limit_minus1_psel_lit", psel_cnt, 9);
    send(1'b1, 10'h052, 32'h5555_AAAA, TO, 1'b0);
    wait_idle();
    chk("limit_timeout_lit", bus.rsp_timeout, TO_EN ? 1 : 0);
    chk("limit_err_lit", bus.rsp_err, TO_EN ? 1 : 0);

    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom);
      w  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
      e  = ($urandom_range(0, 4) == 0);
      send(wr, 10'h100 + 10'($urandom_range(0, 15)), $urandom, w, e);
      repeat ($urandom_range(0, 2)) begin
        @(posedge PCLK);
        #1;
      end
    end
    wait_idle();
    for (int i = 0; i < 16; i++) chk("final_mem", smem[10'h100 + i], mem_m[10'h100 + i]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
